// File: rtl/tmp_sensor_i2c_reader.sv
// rtl/tmp_sensor_i2c_reader.sv - I2C master polling the P3T1035/P3T2030 temperature register
// Define I2C_CLK_STRETCH_EN to let the target stretch SCL in every SCL-release quarter.
module tmp_sensor_i2c_reader #(
    parameter int         CLK_DIV     = 25,
    parameter logic [6:0] SENSOR_ADDR = 7'h48,
    parameter logic [7:0] TEMP_PTR    = 8'h00,
    parameter int         POLL_CYCLES = 100000,
    parameter int         CU_WIDTH    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                poll_en,
    input  logic                scl_i,
    input  logic                sda_i,
    output logic                scl_oe,
    output logic                sda_oe,
    output logic [CU_WIDTH-1:0] sensor_out,
    output logic                sensor_data_valid,
    output logic                nack_err,
    output logic                busy
);
    localparam int QW = $clog2(CLK_DIV);
    localparam int WW = $clog2(POLL_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_PTR, S_RSTART,
        S_ADDR_R, S_RD_MSB, S_RD_LSB, S_STOP, S_WAIT
    } state_t;

    state_t        state, state_n;
    logic [1:0]    q, q_n;
    logic [3:0]    bit_idx, bit_n;
    logic [QW-1:0] qcnt;
    logic [WW-1:0] wait_cnt;
    logic [1:0]    sda_sync;
    logic          sda_s;
    logic [7:0]    rx_shift, msb, txb;
    logic          nack_flag, tick, hold, seg_end, data_st, scl_n, sda_n, busy_n;

    assign sda_s = sda_sync[1];

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] scl_sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scl_sync <= 2'b11;
        else        scl_sync <= {scl_sync[0], scl_i};
    end
    // Quarter 1 of every bus element is the one that releases SCL.
    assign hold = (state inside {S_START, S_ADDR_W, S_PTR, S_RSTART, S_ADDR_R,
                                 S_RD_MSB, S_RD_LSB, S_STOP})
                  && (q == 2'd1) && !scl_sync[1];
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign hold = 1'b0;
`endif

    assign data_st = state inside {S_ADDR_W, S_PTR, S_ADDR_R, S_RD_MSB, S_RD_LSB};
    assign tick    = (state != S_WAIT) && !(state == S_IDLE && !poll_en) && !hold
                     && (qcnt == QW'(CLK_DIV - 1));
    assign seg_end = (q == 2'd3) && (data_st ? (bit_idx == 4'd8) :
                                     (state == S_STOP) ? (bit_idx == 4'd1) : 1'b1);

    function automatic logic [7:0] tx_byte(input state_t s);
        logic [7:0] b;
        case (s)
            S_ADDR_W: b = {SENSOR_ADDR, 1'b0};
            S_PTR:    b = TEMP_PTR;
            default:  b = {SENSOR_ADDR, 1'b1};
        endcase
        return b;
    endfunction

    always_comb begin
        state_n = state;
        q_n     = q;
        bit_n   = bit_idx;
        case (state)
            S_IDLE: if (tick) begin
                state_n = S_START;
                q_n     = 2'd0;
                bit_n   = 4'd0;
            end
            S_WAIT: if (wait_cnt == WW'(POLL_CYCLES - 1)) state_n = S_IDLE;
            default: if (tick) begin
                q_n = q + 2'd1;
                if (q == 2'd3) begin
                    bit_n = bit_idx + 4'd1;
                    if (seg_end) begin
                        bit_n = 4'd0;
                        case (state)
                            S_START:  state_n = S_ADDR_W;
                            S_ADDR_W: state_n = nack_flag ? S_STOP : S_PTR;
                            S_PTR:    state_n = nack_flag ? S_STOP : S_RSTART;
                            S_RSTART: state_n = S_ADDR_R;
                            S_ADDR_R: state_n = nack_flag ? S_STOP : S_RD_MSB;
                            S_RD_MSB: state_n = S_RD_LSB;
                            S_RD_LSB: state_n = S_STOP;
                            S_STOP:   state_n = S_WAIT;
                            default:  state_n = S_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Pad drive is decoded from the next state so the output flops line up with the FSM.
    always_comb begin
        scl_n  = 1'b0;
        sda_n  = 1'b0;
        txb    = tx_byte(state_n);
        busy_n = state_n inside {S_START, S_ADDR_W, S_PTR, S_RSTART, S_ADDR_R,
                                 S_RD_MSB, S_RD_LSB, S_STOP};
        case (state_n)
            S_START: begin
                scl_n = (q_n == 2'd3);
                sda_n = (q_n >= 2'd2);
            end
            S_RSTART: begin
                scl_n = (q_n == 2'd0) || (q_n == 2'd3);
                sda_n = (q_n >= 2'd2);
            end
            S_STOP: if (bit_n == 4'd0) begin
                scl_n = (q_n == 2'd0);
                sda_n = (q_n <= 2'd1);
            end
            S_ADDR_W, S_PTR, S_ADDR_R: begin
                scl_n = (q_n == 2'd0) || (q_n == 2'd3);
                sda_n = (bit_n < 4'd8) && !txb[3'd7 - bit_n[2:0]];
            end
            S_RD_MSB: begin
                scl_n = (q_n == 2'd0) || (q_n == 2'd3);
                sda_n = (bit_n == 4'd8);
            end
            S_RD_LSB: scl_n = (q_n == 2'd0) || (q_n == 2'd3);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            q                 <= 2'd0;
            bit_idx           <= 4'd0;
            qcnt              <= '0;
            wait_cnt          <= '0;
            sda_sync          <= 2'b11;
            rx_shift          <= 8'h00;
            msb               <= 8'h00;
            nack_flag         <= 1'b0;
            scl_oe            <= 1'b0;
            sda_oe            <= 1'b0;
            busy              <= 1'b0;
            sensor_out        <= '0;
            sensor_data_valid <= 1'b0;
            nack_err          <= 1'b0;
        end else begin
            state             <= state_n;
            q                 <= q_n;
            bit_idx           <= bit_n;
            scl_oe            <= scl_n;
            sda_oe            <= sda_n;
            busy              <= busy_n;
            sda_sync          <= {sda_sync[0], sda_i};
            sensor_data_valid <= 1'b0;
            nack_err          <= 1'b0;
            wait_cnt          <= (state == S_WAIT) ? wait_cnt + WW'(1) : '0;
            if (state == S_WAIT || (state == S_IDLE && !poll_en))
                qcnt <= '0;
            else if (!hold)
                qcnt <= (qcnt == QW'(CLK_DIV - 1)) ? '0 : qcnt + QW'(1);
            if (state == S_IDLE)
                nack_flag <= 1'b0;
            if (tick && q == 2'd2) begin
                if (bit_idx == 4'd8 && (state inside {S_ADDR_W, S_PTR, S_ADDR_R}) && sda_s)
                    nack_flag <= 1'b1;
                if (bit_idx < 4'd8 && (state inside {S_RD_MSB, S_RD_LSB}))
                    rx_shift <= {rx_shift[6:0], sda_s};
            end
            if (tick && seg_end) begin
                if (state == S_RD_MSB)
                    msb <= rx_shift;
                if (state == S_STOP) begin
                    if (nack_flag) begin
                        nack_err <= 1'b1;
                    end else begin
                        sensor_out        <= CU_WIDTH'({msb, rx_shift});
                        sensor_data_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tmp_sensor_i2c_reader.sv
// tb/tb_tmp_sensor_i2c_reader.sv - scoreboard bench with a behavioural P3T1035 target at 0x48
module tb_tmp_sensor_i2c_reader;
    logic        clk = 1'b0;
    logic        rst_n, poll_en;
    logic        scl_oe, sda_oe, sensor_data_valid, nack_err, busy;
    logic [15:0] sensor_out;
    logic        m_scl_low = 1'b0, m_sda_low = 1'b0;
    logic        scl_bus, sda_bus;

    assign scl_bus = !(scl_oe || m_scl_low);
    assign sda_bus = !(sda_oe || m_sda_low);

    tmp_sensor_i2c_reader #(.CLK_DIV(4), .POLL_CYCLES(200)) dut (
        .clk(clk), .rst_n(rst_n), .poll_en(poll_en),
        .scl_i(scl_bus), .sda_i(sda_bus),
        .scl_oe(scl_oe), .sda_oe(sda_oe),
        .sensor_out(sensor_out), .sensor_data_valid(sensor_data_valid),
        .nack_err(nack_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Target model state
    logic        nack_addr = 1'b0, stretch_en = 1'b0;
    logic [15:0] rdata = 16'h1900;
    logic [8:0]  bus_log[$];
    logic        mack[$];
    int          rise_t[$];
    logic        scl_p, sda_p, act, rd, first, hit, mack_last;
    logic [7:0]  sh, tx;
    int          bitcnt, nb, bidx, stretch_cnt;

    always @(posedge clk) begin
        if (!rst_n) begin
            scl_p = 1'b1; sda_p = 1'b1; act = 1'b0; rd = 1'b0; first = 1'b0; hit = 1'b0;
            bitcnt = 0; nb = 0; bidx = 0; stretch_cnt = 0; mack_last = 1'b0;
            m_sda_low <= 1'b0; m_scl_low <= 1'b0;
        end else begin
            if (stretch_cnt > 0) begin
                stretch_cnt--;
                if (stretch_cnt == 0) m_scl_low <= 1'b0;
            end
            if (scl_p && scl_bus && sda_p && !sda_bus) begin
                bus_log.push_back(9'h100);
                act = 1'b1; rd = 1'b0; first = 1'b1; bitcnt = -1; nb = 0;
                m_sda_low <= 1'b0;
            end else if (scl_p && scl_bus && !sda_p && sda_bus) begin
                bus_log.push_back(9'h101);
                act = 1'b0; rd = 1'b0;
                m_sda_low <= 1'b0;
            end else if (act && !scl_p && scl_bus) begin
                rise_t.push_back(cyc);
                if (!rd && bitcnt >= 0 && bitcnt < 8) sh = {sh[6:0], sda_bus};
                if (rd && bitcnt == 8) begin
                    mack_last = !sda_bus;
                    mack.push_back(mack_last);
                end
            end else if (act && scl_p && !scl_bus) begin
                if (!rd) begin
                    if (bitcnt < 7) bitcnt++;
                    else if (bitcnt == 7) begin
                        bitcnt = 8;
                        bus_log.push_back({1'b0, sh});
                        if (first) hit = (sh[7:1] == 7'h48) && !nack_addr;
                        m_sda_low <= hit;
                        if (hit && !first && nb == 1 && stretch_en) begin
                            stretch_cnt = 50;
                            m_scl_low <= 1'b1;
                        end
                    end else begin
                        bitcnt = 0;
                        m_sda_low <= 1'b0;
                        if (first && hit && sh[0]) begin
                            rd = 1'b1; bidx = 0; tx = rdata[15:8];
                            m_sda_low <= !tx[7];
                        end
                        if (!hit) act = 1'b0;
                        first = 1'b0;
                        nb++;
                    end
                end else begin
                    if (bitcnt < 7) begin
                        bitcnt++;
                        m_sda_low <= !tx[7 - bitcnt];
                    end else if (bitcnt == 7) begin
                        bitcnt = 8;
                        m_sda_low <= 1'b0;
                    end else begin
                        bitcnt = 0;
                        if (mack_last && bidx == 0) begin
                            bidx = 1; tx = rdata[7:0];
                            m_sda_low <= !tx[7];
                        end else begin
                            rd = 1'b0; act = 1'b0;
                            m_sda_low <= 1'b0;
                        end
                    end
                end
            end
            scl_p = scl_bus;
            sda_p = sda_bus;
        end
    end

    // Scoreboard monitor plus busy-window tracking
    typedef struct { logic nack; logic [15:0] data; } exp_t;
    exp_t exp_q[$];
    int   busy_cnt = 0, last_len = 0, rise_cyc = 0, fall_cyc = 0;
    logic busy_d = 1'b0, valid_d = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_d = 1'b0; busy_cnt = 0; valid_d = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (busy && !busy_d) rise_cyc = cyc;
            if (!busy && busy_d) begin
                fall_cyc = cyc; last_len = busy_cnt; busy_cnt = 0;
            end
            busy_d = busy;
            if (sensor_data_valid || nack_err) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_pulse: valid=%0b nack=%0b sensor_out=%0h",
                             sensor_data_valid, nack_err, sensor_out);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", {sensor_data_valid, nack_err}, e.nack ? 2'b01 : 2'b10);
                    check("sensor_out", sensor_out, e.data);
                end
            end
            if (sensor_data_valid) check("valid_one_clk", valid_d, 1'b0);
            valid_d = sensor_data_valid;
        end
    end

    task automatic wait_sig(input int which, input int budget, input string name);
        int  n = 0;
        bit  seen = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            case (which)
                0:       seen = sensor_data_valid;
                1:       seen = nack_err;
                2:       seen = busy;
                default: seen = !busy;
            endcase
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL %s: timeout after %0d cycles", name, budget);
        end
    endtask

    task automatic check_log(input string name, input logic [8:0] e[$]);
        check({name, "_len"}, bus_log.size(), e.size());
        for (int i = 0; i < e.size() && i < bus_log.size(); i++)
            check(name, bus_log[i], e[i]);
    endtask

    task automatic check_mack(input string name);
        check({name, "_len"}, mack.size(), 2);
        if (mack.size() == 2) begin
            check({name, "_msb_ack"}, mack[0], 1'b1);
            check({name, "_lsb_nack"}, mack[1], 1'b0);
        end
    endtask

    task automatic clear_logs();
        bus_log.delete();
        mack.delete();
        rise_t.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] full_log[$];
        logic [8:0] nack_log[$];
        int t0, fall1, seen;
        full_log = '{9'h100, 9'h090, 9'h000, 9'h100, 9'h091, 9'h101};
        nack_log = '{9'h100, 9'h090, 9'h101};
        rst_n = 1'b0;
        poll_en = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_scl_oe", scl_oe, 1'b0);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_sensor_out", sensor_out, 16'h0000);
        check("rst_valid", sensor_data_valid, 1'b0);
        check("rst_nack", nack_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reading 0x1900
        clear_logs();
        exp_q.push_back('{1'b0, 16'h1900});
        @(posedge clk); #1 poll_en = 1'b1;
        t0 = cyc;
        wait_sig(0, 2000, "t1_valid");
        @(negedge clk);
        check("t1_start_latency", rise_cyc - t0, 4);
`ifdef I2C_CLK_STRETCH_EN
        check("t1_busy_len_min", last_len >= 784, 1'b1);
`else
        check("t1_busy_len", last_len, 784);
        if (rise_t.size() > 2) check("t1_scl_period", rise_t[2] - rise_t[1], 16);
        else check("t1_scl_rises", rise_t.size(), 3);
`endif
        check_log("t1_log", full_log);
        check_mack("t1_mack");
        fall1 = fall_cyc;

        // Address NACK on the next poll
        nack_addr = 1'b1;
        clear_logs();
        exp_q.push_back('{1'b1, 16'h1900});
        wait_sig(1, 2000, "t2_nack");
        @(negedge clk);
        check("t2_poll_gap", rise_cyc - fall1, 204);
`ifdef I2C_CLK_STRETCH_EN
        check("t2_busy_len_min", last_len >= 192, 1'b1);
`else
        check("t2_busy_len", last_len, 192);
`endif
        check_log("t2_log", nack_log);

        // Negative reading, poll_en dropped mid-transaction
        nack_addr = 1'b0;
        rdata = 16'hE700;
        clear_logs();
        exp_q.push_back('{1'b0, 16'hE700});
        wait_sig(2, 1000, "t3_busy");
        repeat (100) @(negedge clk);
        poll_en = 1'b0;
        wait_sig(0, 2000, "t3_valid");
        @(negedge clk);
        check_log("t3_log", full_log);
        check_mack("t3_mack");
        seen = 0;
        repeat (600) begin
            @(negedge clk);
            if (busy) seen++;
        end
        check("t3_no_restart", seen, 0);

        // Reset in the middle of the MSB read
        rdata = 16'h1900;
        clear_logs();
        exp_q.push_back('{1'b0, 16'h1900});
        poll_en = 1'b1;
        wait_sig(2, 1000, "t4_busy");
        repeat (513) @(negedge clk);
`ifndef I2C_CLK_STRETCH_EN
        check("t4_pre_reset_scl_oe", scl_oe, 1'b1);
`endif
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_scl_oe", scl_oe, 1'b0);
        check("t4_rst_sda_oe", sda_oe, 1'b0);
        check("t4_rst_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
        wait_sig(0, 3000, "t4_valid");
        @(negedge clk);
        check_log("t4_log", full_log);

`ifdef I2C_CLK_STRETCH_EN
        // Target stretches SCL during the pointer ACK
        stretch_en = 1'b1;
        clear_logs();
        exp_q.push_back('{1'b0, 16'h1900});
        wait_sig(0, 3000, "t5_valid");
        @(negedge clk);
        check_log("t5_log", full_log);
        check("t5_busy_len_stretched", last_len >= 834, 1'b1);
        check_mack("t5_mack");
        stretch_en = 1'b0;
`endif

        poll_en = 1'b0;
        wait_sig(3, 1000, "end_idle");
        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
